// File: rtl/note_highway.sv
// Scrolling 8-lane note highway: chart row intake, per-frame scroll, pixel decode
// for gems and fret buttons, and hit/miss judging at the strike row.
module note_highway #(
    parameter int ROWS       = 14,
    parameter int LOG2_ROW_H = 5,
    parameter int SPEED      = 2,
    parameter int HWY_X0     = 160,
    parameter int LANE_W     = 40,
    parameter int HWY_Y0     = 0,
    parameter int GEM_H      = 16,
    parameter int GEM_MARGIN = 4,
    parameter int FB_Y0      = 448,
    parameter int FB_H       = 16
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        frame_tick,
    input  logic [9:0]  DrawX,
    input  logic [9:0]  DrawY,
    input  logic        note_valid,
    input  logic [7:0]  note_data,
    output logic        note_ready,
    input  logic [7:0]  keys,
    output logic [7:0]  is_sr,
    output logic [7:0]  is_fb,
    output logic [7:0]  keyTrack,
    output logic        hit_pulse,
    output logic        miss_pulse,
    output logic [15:0] hit_count,
    output logic [15:0] miss_count
);

    localparam int ROW_H = 1 << LOG2_ROW_H;
    localparam logic [LOG2_ROW_H:0]   SPEED_W = SPEED[LOG2_ROW_H:0];
    localparam logic [LOG2_ROW_H:0]   ROW_H_W = ROW_H[LOG2_ROW_H:0];
    localparam logic [LOG2_ROW_H-1:0] GEM_H_W = GEM_H[LOG2_ROW_H-1:0];
    localparam logic signed [10:0] HWY_Y0_S = HWY_Y0[10:0];
    localparam logic signed [10:0] FB_Y0_S  = FB_Y0[10:0];
    localparam logic signed [10:0] FB_Y1_S  = 11'(FB_Y0 + FB_H);
    localparam logic signed [10:0] GEM_L_S  = GEM_MARGIN[10:0];
    localparam logic signed [10:0] GEM_R_S  = 11'(LANE_W - GEM_MARGIN);
    localparam logic signed [10:0] LANE_W_S = LANE_W[10:0];

    logic [7:0]            rows [ROWS];
    logic [LOG2_ROW_H-1:0] offset;
    logic [LOG2_ROW_H:0]   offset_sum;
    logic                  shift;
    logic [7:0]            key_meta;
    logic [7:0]            key_prev;
    logic [7:0]            key_rise;
    logic [7:0]            hit_bits;
    logic [7:0]            strike_left;
    logic [3:0]            hit_n;
    logic [3:0]            miss_n;
    logic [16:0]           hit_sum;
    logic [16:0]           miss_sum;

    logic signed [10:0] y_pos;
    logic signed [10:0] x_pos;
    logic signed [10:0] y_diff;
    logic signed [10:0] row_k;
    logic signed [10:0] lane_x0;
    logic               row_ok;
    logic               gem_y;
    logic               fb_y;
    logic [7:0]         sel_row;

    // A wrap of the sub-row offset is what moves the whole buffer down one row.
    assign offset_sum = {1'b0, offset} + SPEED_W;
    assign shift      = frame_tick && (offset_sum >= ROW_H_W);
    assign note_ready = shift && !Reset;

    // Hits are judged on the pre-shift strike row; bits hit now never count as misses.
    assign key_rise    = keyTrack & ~key_prev;
    assign hit_bits    = key_rise & rows[ROWS-1];
    assign strike_left = rows[ROWS-1] & ~hit_bits;
    assign hit_n       = 4'($countones(hit_bits));
    assign miss_n      = shift ? 4'($countones(strike_left)) : 4'd0;
    assign hit_sum     = {1'b0, hit_count} + {13'd0, hit_n};
    assign miss_sum    = {1'b0, miss_count} + {13'd0, miss_n};

    always_ff @(posedge Clk) begin
        if (Reset) begin
            for (int r = 0; r < ROWS; r++) begin
                rows[r] <= '0;
            end
            offset     <= '0;
            key_meta   <= '0;
            keyTrack   <= '0;
            key_prev   <= '0;
            hit_count  <= '0;
            miss_count <= '0;
            hit_pulse  <= 1'b0;
            miss_pulse <= 1'b0;
        end else begin
            key_meta <= keys;
            keyTrack <= key_meta;
            key_prev <= keyTrack;
            if (frame_tick) begin
                offset <= offset_sum[LOG2_ROW_H-1:0];
            end
            if (shift) begin
                for (int r = ROWS - 1; r > 0; r--) begin
                    rows[r] <= rows[r-1];
                end
                rows[0] <= note_valid ? note_data : 8'h00;
            end else begin
                rows[ROWS-1] <= strike_left;
            end
            hit_count  <= hit_sum[16]  ? 16'hFFFF : hit_sum[15:0];
            miss_count <= miss_sum[16] ? 16'hFFFF : miss_sum[15:0];
            hit_pulse  <= (hit_n != 4'd0);
            miss_pulse <= (miss_n != 4'd0);
        end
    end

    // Signed 11-bit pixel math so rows above the scrolled-in offset decode as empty.
    always_comb begin
        is_sr   = '0;
        is_fb   = '0;
        sel_row = '0;
        lane_x0 = '0;
        y_pos   = $signed({1'b0, DrawY});
        x_pos   = $signed({1'b0, DrawX});
        y_diff  = y_pos - HWY_Y0_S - $signed(11'(offset));
        row_k   = y_diff >>> LOG2_ROW_H;
        row_ok  = (y_diff >= 11'sd0) && (row_k < $signed(11'(ROWS)));
        gem_y   = y_diff[LOG2_ROW_H-1:0] < GEM_H_W;
        fb_y    = (y_pos >= FB_Y0_S) && (y_pos < FB_Y1_S);
        for (int r = 0; r < ROWS; r++) begin
            if (row_ok && (row_k == $signed(11'(r)))) begin
                sel_row = rows[r];
            end
        end
        for (int i = 0; i < 8; i++) begin
            lane_x0  = $signed(11'(HWY_X0 + (7 - i) * LANE_W));
            is_sr[i] = row_ok && gem_y && sel_row[i] &&
                       (x_pos >= lane_x0 + GEM_L_S) && (x_pos < lane_x0 + GEM_R_S);
            is_fb[i] = fb_y && (x_pos >= lane_x0) && (x_pos < lane_x0 + LANE_W_S);
        end
    end

endmodule

// File: tb/tb_note_highway.sv
// Bench for note_highway: a pixel/row-level reference model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_note_highway;

    logic        Clk;
    logic        Reset;
    logic        frame_tick;
    logic [9:0]  DrawX;
    logic [9:0]  DrawY;
    logic        note_valid;
    logic [7:0]  note_data;
    logic        note_ready;
    logic [7:0]  keys;
    logic [7:0]  is_sr;
    logic [7:0]  is_fb;
    logic [7:0]  keyTrack;
    logic        hit_pulse;
    logic        miss_pulse;
    logic [15:0] hit_count;
    logic [15:0] miss_count;

    note_highway dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .frame_tick (frame_tick),
        .DrawX      (DrawX),
        .DrawY      (DrawY),
        .note_valid (note_valid),
        .note_data  (note_data),
        .note_ready (note_ready),
        .keys       (keys),
        .is_sr      (is_sr),
        .is_fb      (is_fb),
        .keyTrack   (keyTrack),
        .hit_pulse  (hit_pulse),
        .miss_pulse (miss_pulse),
        .hit_count  (hit_count),
        .miss_count (miss_count)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    // Reference model state
    logic [7:0]  m_rows [14];
    int          m_off;
    logic [7:0]  m_khist [3];
    logic        m_hit_pulse;
    logic        m_miss_pulse;
    int          m_hits;
    int          m_misses;
    logic        model_live = 1'b0;
    logic        preload = 1'b0;

    // Literal expectations captured by the stimulus, judged by the compare process
    string       lit_nm  [128];
    logic [15:0] lit_act [128];
    logic [15:0] lit_exp [128];
    int          lit_wr = 0;
    int          lit_rd = 0;

    int n_pass  = 0;
    int n_total = 0;

    function automatic logic [7:0] exp_sr(input int x, input int y);
        int d;
        int k;
        int col;
        int xin;
        d = y - 0 - m_off;
        if (d < 0) return 8'h00;
        k = d / 32;
        if (k >= 14 || (d % 32) >= 16) return 8'h00;
        if (x < 160 || x >= 480) return 8'h00;
        col = (x - 160) / 40;
        xin = (x - 160) % 40;
        if (xin < 4 || xin >= 36) return 8'h00;
        return m_rows[k][7-col] ? (8'h01 << (7 - col)) : 8'h00;
    endfunction

    function automatic logic [7:0] exp_fb(input int x, input int y);
        if (y < 448 || y >= 464 || x < 160 || x >= 480) return 8'h00;
        return 8'h01 << (7 - (x - 160) / 40);
    endfunction

    // Model advances on each clock edge from the inputs the bench is presenting.
    always @(posedge Clk) begin : model
        logic [7:0] rise;
        logic [7:0] hit;
        logic       shifting;
        int         missed;
        if (Reset) begin
            model_live = 1'b1;
            for (int r = 0; r < 14; r++) m_rows[r] = 8'h00;
            for (int j = 0; j < 3; j++) m_khist[j] = 8'h00;
            m_off = 0;
            m_hit_pulse = 1'b0;
            m_miss_pulse = 1'b0;
            m_hits = 0;
            m_misses = 0;
        end else begin
            rise     = m_khist[1] & ~m_khist[2];
            hit      = rise & m_rows[13];
            shifting = frame_tick && (m_off + 2 >= 32);
            missed   = shifting ? $countones(m_rows[13] & ~hit) : 0;
            m_hit_pulse  = (hit != 8'h00);
            m_miss_pulse = (missed != 0);
            m_hits   = (m_hits + $countones(hit) > 65535) ? 65535 : m_hits + $countones(hit);
            m_misses = (m_misses + missed > 65535) ? 65535 : m_misses + missed;
            m_rows[13] = m_rows[13] & ~hit;
            if (frame_tick) begin
                m_off = m_off + 2;
                if (m_off >= 32) begin
                    m_off = m_off - 32;
                    for (int r = 13; r > 0; r--) m_rows[r] = m_rows[r-1];
                    m_rows[0] = note_valid ? note_data : 8'h00;
                end
            end
            m_khist[2] = m_khist[1];
            m_khist[1] = m_khist[0];
            m_khist[0] = keys;
            if (preload) m_misses = 65534;
        end
    end

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    endtask

    // Single compare process: model vs DUT every cycle, then any queued literal checks.
    always @(negedge Clk) begin
        if (model_live) begin
            check("is_sr", {8'h00, is_sr}, {8'h00, exp_sr(int'(DrawX), int'(DrawY))});
            check("is_fb", {8'h00, is_fb}, {8'h00, exp_fb(int'(DrawX), int'(DrawY))});
            check("note_ready", {15'd0, note_ready},
                  {15'd0, !Reset && frame_tick && (m_off + 2 >= 32)});
            check("keyTrack", {8'h00, keyTrack}, {8'h00, m_khist[1]});
            check("hit_pulse", {15'd0, hit_pulse}, {15'd0, m_hit_pulse});
            check("miss_pulse", {15'd0, miss_pulse}, {15'd0, m_miss_pulse});
            check("hit_count", hit_count, 16'(m_hits));
            if (!preload) check("miss_count", miss_count, 16'(m_misses));
        end
        while (lit_rd != lit_wr) begin
            check(lit_nm[lit_rd % 128], lit_act[lit_rd % 128], lit_exp[lit_rd % 128]);
            lit_rd++;
        end
    end

    task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
        lit_nm[lit_wr % 128]  = name;
        lit_act[lit_wr % 128] = act;
        lit_exp[lit_wr % 128] = exp;
        lit_wr++;
    endtask

    task automatic cyc();
        @(posedge Clk);
        #1;
    endtask

    task automatic tick(output logic rdy);
        frame_tick = 1'b1;
        #1;
        rdy = note_ready;
        cyc();
        frame_tick = 1'b0;
        cyc();
    endtask

    task automatic advance_row(input logic v, input logic [7:0] d);
        logic r;
        note_valid = v;
        note_data  = d;
        repeat (16) tick(r);
        note_valid = 1'b0;
        note_data  = 8'h00;
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        cyc();
        cyc();
        Reset = 1'b0;
    endtask

    task automatic load_strike(input logic [7:0] d);
        do_reset();
        advance_row(1'b1, d);
        repeat (13) advance_row(1'b0, 8'h00);
    endtask

    task automatic applyStimulus(input int x, input int y);
        DrawX = 10'(x);
        DrawY = 10'(y);
        #1;
    endtask

    initial begin
        logic r;
        int   ready_cnt;
        int   ready_at;
        Reset = 1'b1;
        frame_tick = 1'b0;
        DrawX = 10'd0;
        DrawY = 10'd0;
        note_valid = 1'b0;
        note_data = 8'h00;
        keys = 8'h00;
        cyc();

        // Reset state and fret-button strip boundaries
        do_reset();
        applyStimulus(200, 10);
        checkOutput("rst_is_sr", {8'h00, is_sr}, 16'h0000);
        checkOutput("rst_is_fb", {8'h00, is_fb}, 16'h0000);
        checkOutput("rst_hit_count", hit_count, 16'h0000);
        checkOutput("rst_miss_count", miss_count, 16'h0000);
        checkOutput("rst_note_ready", {15'd0, note_ready}, 16'h0000);
        checkOutput("rst_keyTrack", {8'h00, keyTrack}, 16'h0000);
        cyc();
        applyStimulus(170, 450); checkOutput("fb_lane7", {8'h00, is_fb}, 16'h0080); cyc();
        applyStimulus(479, 463); checkOutput("fb_lane0_edge", {8'h00, is_fb}, 16'h0001); cyc();
        applyStimulus(480, 450); checkOutput("fb_right_out", {8'h00, is_fb}, 16'h0000); cyc();
        applyStimulus(170, 464); checkOutput("fb_below", {8'h00, is_fb}, 16'h0000); cyc();
        applyStimulus(200, 448); checkOutput("fb_lane6_top", {8'h00, is_fb}, 16'h0040); cyc();

        // Row intake: ready pulses only on the 16th tick; gem probes after tick 17
        note_valid = 1'b1;
        note_data  = 8'h80;
        ready_cnt  = 0;
        ready_at   = 0;
        for (int t = 1; t <= 16; t++) begin
            tick(r);
            if (r) begin
                ready_cnt++;
                ready_at = t;
            end
        end
        note_valid = 1'b0;
        note_data  = 8'h00;
        checkOutput("ready_pulses", 16'(ready_cnt), 16'd1);
        checkOutput("ready_tick", 16'(ready_at), 16'd16);
        tick(r);
        applyStimulus(170, 5);  checkOutput("gem_probe", {8'h00, is_sr}, 16'h0080); cyc();
        applyStimulus(170, 17); checkOutput("gem_last_line", {8'h00, is_sr}, 16'h0080); cyc();
        applyStimulus(170, 18); checkOutput("gem_below", {8'h00, is_sr}, 16'h0000); cyc();
        applyStimulus(170, 1);  checkOutput("above_offset", {8'h00, is_sr}, 16'h0000); cyc();
        applyStimulus(163, 5);  checkOutput("gem_left_margin", {8'h00, is_sr}, 16'h0000); cyc();
        applyStimulus(164, 5);  checkOutput("gem_left_edge", {8'h00, is_sr}, 16'h0080); cyc();
        applyStimulus(195, 5);  checkOutput("gem_right_edge", {8'h00, is_sr}, 16'h0080); cyc();
        applyStimulus(196, 5);  checkOutput("gem_right_margin", {8'h00, is_sr}, 16'h0000); cyc();

        // Hit on lane 0 at the strike row; leaving row then counts no miss
        load_strike(8'h01);
        applyStimulus(455, 440);
        keys = 8'h01;
        cyc();
        cyc();
        checkOutput("hit_keyTrack", {8'h00, keyTrack}, 16'h0001);
        checkOutput("hit_pulse_early", {15'd0, hit_pulse}, 16'h0000);
        cyc();
        checkOutput("hit_pulse", {15'd0, hit_pulse}, 16'h0001);
        checkOutput("hit_count_1", hit_count, 16'd1);
        cyc();
        checkOutput("hit_pulse_once", {15'd0, hit_pulse}, 16'h0000);
        keys = 8'h00;
        advance_row(1'b0, 8'h00);
        checkOutput("hit_no_miss", miss_count, 16'd0);
        checkOutput("hit_count_kept", hit_count, 16'd1);

        // Four unplayed notes leave the strike row
        load_strike(8'h0F);
        repeat (15) tick(r);
        frame_tick = 1'b1;
        cyc();
        checkOutput("miss_pulse", {15'd0, miss_pulse}, 16'h0001);
        checkOutput("miss_count_4", miss_count, 16'd4);
        frame_tick = 1'b0;
        cyc();
        checkOutput("miss_pulse_once", {15'd0, miss_pulse}, 16'h0000);

        // Key edge coincides with the shifting tick
        load_strike(8'h03);
        repeat (15) tick(r);
        keys = 8'h02;
        cyc();
        cyc();
        frame_tick = 1'b1;
        cyc();
        checkOutput("both_hit_pulse", {15'd0, hit_pulse}, 16'h0001);
        checkOutput("both_miss_pulse", {15'd0, miss_pulse}, 16'h0001);
        checkOutput("both_hit_count", hit_count, 16'd1);
        checkOutput("both_miss_count", miss_count, 16'd1);
        frame_tick = 1'b0;
        keys = 8'h00;
        cyc();

        // Saturation of the miss counter, then a mid-scroll reset
        load_strike(8'hFF);
        force dut.miss_count = 16'hFFFE;
        preload = 1'b1;
        cyc();
        release dut.miss_count;
        preload = 1'b0;
        checkOutput("preload", miss_count, 16'hFFFE);
        repeat (15) tick(r);
        note_valid = 1'b1;
        note_data  = 8'hAA;
        frame_tick = 1'b1;
        cyc();
        note_valid = 1'b0;
        note_data  = 8'h00;
        checkOutput("miss_saturate", miss_count, 16'hFFFF);
        checkOutput("sat_miss_pulse", {15'd0, miss_pulse}, 16'h0001);
        frame_tick = 1'b0;
        cyc();
        repeat (3) tick(r);
        applyStimulus(170, 10);
        checkOutput("pre_reset_gem", {8'h00, is_sr}, 16'h0080);
        Reset = 1'b1;
        cyc();
        checkOutput("reset_gem_gone", {8'h00, is_sr}, 16'h0000);
        checkOutput("reset_miss_count", miss_count, 16'd0);
        Reset = 1'b0;
        applyStimulus(170, 0);
        checkOutput("reset_offset_zero", {8'h00, is_sr}, 16'h0000);
        cyc();
        cyc();
        @(negedge Clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/note_highway.md
Name: note_highway

Overview:
- Upstream feeder of the VGA color mapper; produces its `is_sr`, `is_fb` and `keyTrack` inputs.
- Holds an 8-lane (2 players × 4 lanes) scrolling note buffer, fed row by row from a chart source through a valid/ready handshake.
- Scrolls the buffer once per frame and decodes DrawX/DrawY into per-lane gem and fret-button hit flags.
- Judges key presses against the strike row and keeps saturating hit/miss counters for the score display.

Parameters:
- ROWS, 14, number of note rows in the buffer; row 0 is the top row, row ROWS-1 is the strike row.
- LOG2_ROW_H, 5, log2 of row height in pixels (ROW_H = 32).
- SPEED, 2, pixels scrolled per frame; must satisfy 1 ≤ SPEED < ROW_H.
- HWY_X0, 160, left x of lane 7; lane i spans x in [HWY_X0+(7-i)*LANE_W, +LANE_W).
- LANE_W, 40, lane width in pixels.
- HWY_Y0, 0, top y of the highway.
- GEM_H, 16, gem height from the top of its row.
- GEM_MARGIN, 4, horizontal inset of a gem inside its lane, applied on each side.
- FB_Y0, 448, top y of the fret-button strip.
- FB_H, 16, fret-button strip height.

Ports:
- Clk, in, 1, system clock.
- Reset, in, 1, synchronous, active-high.
- frame_tick, in, 1, one-cycle pulse per frame (vsync edge).
- DrawX, in, 10, current pixel x.
- DrawY, in, 10, current pixel y.
- note_valid, in, 1, chart source has a row available.
- note_data, in, 8, row bitmap; bit i set = note in lane i.
- note_ready, out, 1, row consumed this cycle when note_valid is also high.
- keys, in, 8, raw asynchronous fret keys, active-high.
- is_sr, out, 8, pixel lies on a live gem in lane i.
- is_fb, out, 8, pixel lies in the fret button of lane i.
- keyTrack, out, 8, synchronized key state.
- hit_pulse, out, 1, one-cycle pulse on each hit.
- miss_pulse, out, 1, one-cycle pulse when a row leaves with live notes.
- hit_count, out, 16, saturating hit count.
- miss_count, out, 16, saturating count of missed notes.

Behaviour:
- Reset (synchronous, active-high):
  - All rows, the offset, key synchronizers and counters clear to 0.
  - keyTrack=0, hit_pulse=0, miss_pulse=0, note_ready=0.
  - Reset asserted mid-scroll discards everything on the next edge.
- Key synchronization:
  - 2-FF synchronizer per key; keyTrack = second stage (2-cycle latency).
  - Rising edge detected from keyTrack versus its 1-cycle delayed copy.
- Scroll:
  - Each frame_tick: if offset+SPEED < ROW_H, offset ← offset+SPEED.
  - Otherwise offset ← offset+SPEED−ROW_H and the buffer shifts: row k+1 ← row k; row 0 ← note_data if note_valid, else 8'h00.
  - note_ready is combinational and high only in a shift cycle.
  - The transfer occurs iff note_valid && note_ready. note_data is ignored otherwise; a source that is not valid yields an empty row and no stall.
- Miss:
  - In a shift cycle, the count of set bits in the outgoing strike row (popcount, 0..8) is added to miss_count, saturating at 16'hFFFF.
  - miss_pulse=1 the next cycle if that count is nonzero.
- Hit:
  - When lane i sees a rising edge and strike-row bit i is set, that bit clears.
  - Pressed lanes that hit are counted; the count is added to hit_count (saturating), and hit_pulse=1 the next cycle.
  - Rising edge on an empty lane: no effect.
- Simultaneous hit and shift in the same cycle:
  - The hit is judged against the pre-shift strike row.
  - Bits hit that cycle are excluded from the miss popcount.
  - hit_pulse and miss_pulse may both assert.
- Pixel decode (combinational, same-cycle, no registers):
  - yrel = DrawY−HWY_Y0.
  - Row k = (yrel−offset) >> LOG2_ROW_H, valid when yrel ≥ offset and k < ROWS.
  - is_sr[i] = row[k][i] && ((yrel−offset) mod ROW_H) < GEM_H && DrawX in lane i inset by GEM_MARGIN on each side.
  - Pixels with yrel < offset, beyond row ROWS−1, or outside the lanes give is_sr = 0.
  - is_fb[i] = DrawY in [FB_Y0, FB_Y0+FB_H) && DrawX in lane i (full width).
  - At most one bit of is_sr and at most one bit of is_fb is set at a time.
- Width rules: all pixel arithmetic is 11-bit signed to avoid wrap when DrawY < HWY_Y0.

Test Plan:
1. Reset, then DrawX=200, DrawY=10 → is_sr=0, is_fb=0, hit_count=0, miss_count=0, note_ready=0.
2. note_valid=1, note_data=8'h80; 16 frame_ticks → note_ready pulses once at tick 16 and the row is accepted. Probe DrawX=170, DrawY=5 after tick 17 (offset=2) → is_sr=8'h80.
3. Gem in lane 0 advanced to the strike row; key0 rises → keyTrack[0] high 2 cycles later, hit_pulse one cycle after that, hit_count=1. When the row exits → miss_count unchanged.
4. Strike row = 8'h0F with no keys pressed → on the shift, miss_count += 4 and miss_pulse=1 for one cycle.
5. Strike row = 8'h03; a key1 edge lands in the same cycle as the shifting frame_tick → hit_count += 1, miss_count += 1.
6. miss_count preloaded to 16'hFFFE by forcing; strike row = 8'hFF shifts out → miss_count=16'hFFFF. A Reset pulse mid-scroll then clears all rows and counters on the next edge.
